// File: rtl/mem_initiator_if.sv
// rtl/mem_initiator_if.sv - host request and memory-side handshake bundle for mem_initiator
interface mem_initiator_if #(
    parameter int LEN_W = 4
);
    logic             req_valid;
    logic             req_write;
    logic [LEN_W-1:0] req_len;
    logic             req_ready;
    logic             select;
    logic             op;
    logic             valid_in;
    logic             rw_in;
    logic             err_clear;
    logic             done;
    logic             error;
    logic             busy;
    logic [LEN_W:0]   beat_count;

    modport slave (
        input  req_valid, req_write, req_len, valid_in, rw_in, err_clear,
        output req_ready, select, op, done, error, busy, beat_count
    );

    modport master (
        output req_valid, req_write, req_len, valid_in, rw_in, err_clear,
        input  req_ready, select, op, done, error, busy, beat_count
    );
endinterface

// File: rtl/mem_initiator.sv
// rtl/mem_initiator.sv - burst initiator driving select/op toward a memory-side fsm
module mem_initiator #(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int LEN_W          = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_initiator_if.slave  bus
);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_RELEASE = 3'd3;
    localparam logic [2:0] S_FAULT   = 3'd4;

    logic [2:0]       state_q;
    logic             wr_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   beat_q;
    logic [TMO_W-1:0] tmo_q;

    logic [LEN_W:0]   beat_inc;
    logic [LEN_W:0]   burst_beats;
    logic [TMO_W-1:0] tmo_inc;

    // One extra bit so a maximum-length burst reaches 2^LEN_W without wrapping.
    assign beat_inc    = beat_q + (LEN_W+1)'(1);
    assign burst_beats = {1'b0, len_q} + (LEN_W+1)'(1);
    assign tmo_inc     = tmo_q + TMO_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wr_q    <= 1'b0;
            len_q   <= '0;
            beat_q  <= '0;
            tmo_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        wr_q    <= bus.req_write;
                        len_q   <= bus.req_len;
                        beat_q  <= '0;
                        tmo_q   <= '0;
                        state_q <= S_SETUP;
                    end
                end
                S_SETUP: state_q <= S_ACCESS;
                S_ACCESS: begin
                    if (bus.valid_in) begin
                        if (bus.rw_in == wr_q) begin
                            beat_q <= beat_inc;
                            tmo_q  <= '0;
                            if (beat_inc == burst_beats) begin
                                state_q <= S_RELEASE;
                            end
                        end else begin
                            state_q <= S_FAULT;
                        end
                    end else begin
                        tmo_q <= tmo_inc;
                        if (tmo_inc == TMO_W'(TIMEOUT_CYCLES)) begin
                            state_q <= S_FAULT;
                        end
                    end
                end
                S_RELEASE: state_q <= S_IDLE;
                S_FAULT: begin
                    if (bus.err_clear) begin
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Outputs decode only registered state, so reset drops select immediately.
    assign bus.req_ready  = (state_q == S_IDLE);
    assign bus.select     = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign bus.op         = (state_q == S_ACCESS) && wr_q;
    assign bus.done       = (state_q == S_RELEASE);
    assign bus.error      = (state_q == S_FAULT);
    assign bus.busy       = (state_q != S_IDLE);
    assign bus.beat_count = beat_q;
endmodule

// File: tb/tb_mem_initiator.sv
// tb/tb_mem_initiator.sv - directed vector bench for mem_initiator
module tb_mem_initiator;
    logic clk;
    logic rst_n;

    mem_initiator_if #(.LEN_W(4)) bus ();

    mem_initiator #(.TIMEOUT_CYCLES(15), .LEN_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic       rv;
        logic       wr;
        logic [3:0] len;
        logic       vi;
        logic       ri;
        logic       ec;
        logic [10:0] exp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    function automatic logic [10:0] outs();
        return {bus.req_ready, bus.select, bus.op, bus.done, bus.error, bus.busy, bus.beat_count};
    endfunction

    function automatic logic [10:0] ex(logic rdy, logic sel, logic op, logic dn,
                                       logic er, logic bs, logic [4:0] bc);
        return {rdy, sel, op, dn, er, bs, bc};
    endfunction

    function automatic vec_t v(logic rv, logic wr, logic [3:0] len, logic vi, logic ri,
                               logic ec, logic [10:0] e);
        vec_t t;
        t.rv = rv; t.wr = wr; t.len = len; t.vi = vi; t.ri = ri; t.ec = ec; t.exp = e;
        return t;
    endfunction

    task automatic drive(logic rv, logic wr, logic [3:0] len, logic vi, logic ri, logic ec);
        bus.req_valid = rv;
        bus.req_write = wr;
        bus.req_len   = len;
        bus.valid_in  = vi;
        bus.rw_in     = ri;
        bus.err_clear = ec;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 4'd0, 0, 0, 0);

        // Write burst len=2, valid matching beat every cycle.
        tbl.push_back(v(1, 1, 4'd2, 1, 1, 0, ex(0, 1, 0, 0, 0, 1, 5'd0)));
        tbl.push_back(v(1, 1, 4'd2, 1, 1, 0, ex(0, 1, 1, 0, 0, 1, 5'd0)));
        tbl.push_back(v(1, 1, 4'd2, 1, 1, 0, ex(0, 1, 1, 0, 0, 1, 5'd1)));
        tbl.push_back(v(0, 0, 4'd0, 1, 1, 0, ex(0, 1, 1, 0, 0, 1, 5'd2)));
        tbl.push_back(v(0, 0, 4'd0, 1, 1, 0, ex(0, 0, 0, 1, 0, 1, 5'd3)));
        tbl.push_back(v(0, 0, 4'd0, 1, 1, 0, ex(1, 0, 0, 0, 0, 0, 5'd3)));
        tbl.push_back(v(0, 0, 4'd0, 1, 1, 0, ex(1, 0, 0, 0, 0, 0, 5'd3)));
        // Read burst len=0, beat arrives after 5 idle ACCESS cycles.
        tbl.push_back(v(1, 0, 4'd0, 0, 0, 0, ex(0, 1, 0, 0, 0, 1, 5'd0)));
        tbl.push_back(v(0, 0, 4'd0, 0, 0, 0, ex(0, 1, 0, 0, 0, 1, 5'd0)));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0, 0, 4'd0, 0, 0, 0, ex(0, 1, 0, 0, 0, 1, 5'd0)));
        tbl.push_back(v(0, 0, 4'd0, 1, 0, 0, ex(0, 0, 0, 1, 0, 1, 5'd1)));
        tbl.push_back(v(0, 0, 4'd0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 5'd1)));
        // Mismatch on a write burst, then sticky error until err_clear.
        tbl.push_back(v(1, 1, 4'd3, 0, 0, 0, ex(0, 1, 0, 0, 0, 1, 5'd0)));
        tbl.push_back(v(0, 1, 4'd3, 0, 0, 0, ex(0, 1, 1, 0, 0, 1, 5'd0)));
        tbl.push_back(v(0, 0, 4'd0, 1, 0, 0, ex(0, 0, 0, 0, 1, 1, 5'd0)));
        tbl.push_back(v(1, 0, 4'd0, 1, 1, 0, ex(0, 0, 0, 0, 1, 1, 5'd0)));
        tbl.push_back(v(0, 0, 4'd0, 0, 0, 1, ex(1, 0, 0, 0, 0, 0, 5'd0)));
        tbl.push_back(v(0, 0, 4'd0, 0, 0, 0, ex(1, 0, 0, 0, 0, 0, 5'd0)));

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 32'(outs()), 32'(ex(1, 0, 0, 0, 0, 0, 5'd0)));
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].rv, tbl[i].wr, tbl[i].len, tbl[i].vi, tbl[i].ri, tbl[i].ec);
            step();
            check($sformatf("vec%0d", i), 32'(outs()), 32'(tbl[i].exp));
        end

        // Timeout: no beats, FAULT after exactly 15 ACCESS cycles.
        begin
            int n;
            drive(1, 0, 4'd1, 0, 0, 0);
            step();
            drive(0, 0, 4'd0, 0, 0, 0);
            step();
            check("tmo_access", 32'({bus.select, bus.error}), 32'b10);
            n = 41;
            for (int k = 1; k <= 40; k++) begin
                step();
                if (bus.error) begin
                    n = k;
                    break;
                end
            end
            check("tmo_cycles", 32'(n), 32'd15);
            check("tmo_fault_out", 32'(outs()), 32'(ex(0, 0, 0, 0, 1, 1, 5'd0)));
            repeat (3) step();
            check("tmo_sticky", 32'(bus.error), 32'd1);
            drive(0, 0, 4'd0, 0, 0, 1);
            step();
            drive(0, 0, 4'd0, 0, 0, 0);
            check("tmo_cleared", 32'({bus.error, bus.req_ready}), 32'b01);
        end

        // Maximum length burst: 16 beats, single done.
        begin
            int acc_cnt, done_cnt;
            logic [4:0] done_beats;
            acc_cnt = 0; done_cnt = 0; done_beats = '0;
            drive(1, 1, 4'd15, 1, 1, 0);
            step();
            drive(0, 0, 4'd0, 1, 1, 0);
            for (int k = 0; k < 24; k++) begin
                step();
                if (bus.select && bus.op) acc_cnt++;
                if (bus.done) begin
                    done_cnt++;
                    done_beats = bus.beat_count;
                end
            end
            drive(0, 0, 4'd0, 0, 0, 0);
            check("max_access_cycles", 32'(acc_cnt), 32'd16);
            check("max_done_count", 32'(done_cnt), 32'd1);
            check("max_done_beats", 32'(done_beats), 32'd16);
            check("max_final", 32'(outs()), 32'(ex(1, 0, 0, 0, 0, 0, 5'd16)));
        end

        // Reset mid-burst after two beats.
        begin
            drive(1, 1, 4'd7, 1, 1, 0);
            step();
            drive(0, 0, 4'd0, 1, 1, 0);
            repeat (3) step();
            check("rst_pre", 32'(outs()), 32'(ex(0, 1, 1, 0, 0, 1, 5'd2)));
            rst_n = 1'b0;
            #1;
            check("rst_immediate", 32'(outs()), 32'(ex(1, 0, 0, 0, 0, 0, 5'd0)));
            step();
            check("rst_held", 32'(outs()), 32'(ex(1, 0, 0, 0, 0, 0, 5'd0)));
            rst_n = 1'b1;
            drive(1, 0, 4'd0, 0, 0, 0);
            step();
            drive(0, 0, 4'd0, 0, 0, 0);
            check("rst_new_req", 32'(outs()), 32'(ex(0, 1, 0, 0, 0, 1, 5'd0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
